// File: rtl/hi_lo_multdiv_if.sv
// Start/Busy/Done handshake and HI/LO result bus of the multiply/divide unit.
interface hi_lo_multdiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a, b,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/hi_lo_multdiv.sv
// Iterative radix-2 multiply/divide unit producing the HI/LO register values.
// Multi-cycle ops: IDLE -> CALC (WIDTH steps + one settle cycle) -> FIX.
module hi_lo_multdiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic             Clk,
    input logic             Reset,
    hi_lo_multdiv_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101,
        OpMadd  = 3'b110,
        OpMsub  = 3'b111
    } op_e;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               div0_q, div0_d;
    // acc: product high half / partial remainder
    logic [WIDTH-1:0]   acc_q, acc_d;
    // work: multiplier shifting out, product low half / dividend shifting out, quotient
    logic [WIDTH-1:0]   work_q, work_d;
    // mcand: multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    op_e                op_in;
    logic               in_signed;
    logic               in_long;
    logic               res_neg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    assign op_in     = op_e'(bus.op);
    assign in_signed = (op_in == OpMult) || (op_in == OpDiv) ||
                       (op_in == OpMadd) || (op_in == OpMsub);
    assign in_long   = (op_in != OpMthi) && (op_in != OpMtlo);
    assign res_neg   = a_neg_q ^ b_neg_q;

    // Shift-add step: add multiplicand when multiplier LSB set, then shift {acc,work} right.
    assign mul_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, mcand_q} : '0);

    // Restoring step: shift next dividend bit into remainder, subtract if it fits.
    assign div_trial = {acc_q, work_q[WIDTH-1]};
    assign div_ge    = div_trial >= {1'b0, mcand_q};
    assign div_diff  = div_trial[WIDTH-1:0] - mcand_q;

    // Sign correction on magnitudes; divide-by-zero forces an all-ones quotient.
    assign prod_s    = res_neg ? -{acc_q, work_q} : {acc_q, work_q};
    assign quo_s     = div0_q ? '1 : (res_neg ? -work_q : work_q);
    assign rem_s     = a_neg_q ? -acc_q : acc_q;

    // Next-state and datapath update for every register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        div0_d  = div0_q;
        acc_d   = acc_q;
        work_d  = work_q;
        mcand_d = mcand_q;
        hilo_d  = hilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (in_long) begin
                        a_neg_d = in_signed & bus.a[WIDTH-1];
                        b_neg_d = in_signed & bus.b[WIDTH-1];
                        work_d  = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                        mcand_d = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                        div0_d  = (bus.b == '0);
                        acc_d   = '0;
                        cnt_d   = '0;
                        op_d    = op_in;
                        hilo_d  = {hi_q, lo_q};
                        state_d = StCalc;
                    end else begin
                        if (op_in == OpMthi) begin
                            hi_d = bus.a;
                        end else begin
                            lo_d = bus.a;
                        end
                        done_d = 1'b1;
                    end
                end
            end
            StCalc: begin
                // Counter reaching WIDTH is a settle cycle: no step, just move to FIX.
                if (cnt_q == CntW'(WIDTH)) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (op_q == OpDiv || op_q == OpDivu) begin
                        if (div_ge) begin
                            acc_d  = div_diff;
                            work_d = {work_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d  = div_trial[WIDTH-1:0];
                            work_d = {work_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d  = mul_sum[WIDTH:1];
                        work_d = {mul_sum[0], work_q[WIDTH-1:1]};
                    end
                end
            end
            StFix: begin
                case (op_q)
                    OpDiv, OpDivu: begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
                    OpMadd:  {hi_d, lo_d} = hilo_q + prod_s;
                    OpMsub:  {hi_d, lo_d} = hilo_q - prod_s;
                    default: {hi_d, lo_d} = prod_s;
                endcase
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpMult;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            acc_q   <= '0;
            work_q  <= '0;
            mcand_q <= '0;
            hilo_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            div0_q  <= div0_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            mcand_q <= mcand_d;
            hilo_q  <= hilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = done_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_hi_lo_multdiv.sv
// Self-checking bench for hi_lo_multdiv: directed vector table, corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_hi_lo_multdiv;
    logic clk;
    logic reset;

    hi_lo_multdiv_if #(.WIDTH(32)) bus ();

    hi_lo_multdiv #(.WIDTH(32)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hilo);
        longint prod;
        int     sa;
        int     sb;
        int     q;
        int     m;
        logic [63:0] r;
        sa   = $signed(a);
        sb   = $signed(b);
        prod = longint'(sa) * longint'(sb);
        r    = hilo;
        case (op)
            3'd0: r = prod;
            3'd1: r = {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m, q};
                end
            end
            3'd3: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            3'd4: r = {a, hilo[31:0]};
            3'd5: r = {hilo[63:32], a};
            3'd6: r = hilo + prod;
            default: r = hilo - prod;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue op now (caller sits just after an edge), follow it to Done and check it.
    // inject_at >= 0 raises a stray MULT Start that many cycles into the operation.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at);
        logic [63:0] exp;
        int n;
        int busy_n;
        int exp_lat;
        exp     = ref_op(op, a, b, {m_hi, m_lo});
        exp_lat = (op == 3'd4 || op == 3'd5) ? 0 : 34;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        n      = 0;
        busy_n = bus.busy ? 1 : 0;
        while (!bus.done && n < 100) begin
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.op    = 3'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (bus.busy) busy_n++;
        end
        bus.start = 1'b0;
        chk($sformatf("latency op%0d", op), 64'(n), 64'(exp_lat));
        chk($sformatf("busy_cycles op%0d", op), 64'(busy_n), 64'(exp_lat));
        chk($sformatf("hi op%0d a=%h b=%h", op, a, b), 64'(bus.hi_out), 64'(exp[63:32]));
        chk($sformatf("lo op%0d a=%h b=%h", op, a, b), 64'(bus.lo_out), 64'(exp[31:0]));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        int done_seen;
        logic [2:0] rop;
        n_pass    = 0;
        n_total   = 0;
        m_hi      = 0;
        m_lo      = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 0;
        bus.b     = 0;

        vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'hA,         32'h0,         32'h0000_000A, 32'hFFFF_FFFF};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[5] = '{3'd5, 32'h10,        32'h0,         32'h0,         32'h10};
        vecs[6] = '{3'd4, 32'h0,         32'h0,         32'h0,         32'h10};
        vecs[7] = '{3'd6, 32'h3,         32'h4,         32'h0,         32'h1C};
        vecs[8] = '{3'd7, 32'h1D,        32'h1,         32'hFFFF_FFFF, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset hi", 64'(bus.hi_out), 64'h0);
        chk("reset lo", 64'(bus.lo_out), 64'h0);
        chk("reset busy", 64'(bus.busy), 64'h0);
        chk("reset done", 64'(bus.done), 64'h0);

        // Directed table; each op starts in the previous op's Done cycle.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1);
            chk($sformatf("vec%0d hi", i), 64'(bus.hi_out), 64'(vecs[i].hi));
            chk($sformatf("vec%0d lo", i), 64'(bus.lo_out), 64'(vecs[i].lo));
        end

        // Done lasts one cycle and HI/LO hold afterwards.
        @(posedge clk);
        #1;
        chk("done single pulse", 64'(bus.done), 64'h0);
        chk("hold hi", 64'(bus.hi_out), 64'(m_hi));
        chk("hold lo", 64'(bus.lo_out), 64'(m_lo));

        // Start while busy is ignored.
        run_op(3'd3, 32'd1000, 32'd7, 5);
        run_op(3'd3, $urandom, $urandom_range(1, 1000), 5);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            run_op(rop, rnd_operand(), rnd_operand(), -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset mid-divide: results cleared, no Done ever.
        run_op(3'd4, 32'h1234_5678, 32'h0, -1);
        run_op(3'd5, 32'h9ABC_DEF0, 32'h0, -1);
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0000_0123;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort hi", 64'(bus.hi_out), 64'h0);
        chk("abort lo", 64'(bus.lo_out), 64'h0);
        chk("abort busy", 64'(bus.busy), 64'h0);
        chk("abort done", 64'(bus.done), 64'h0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("no done after abort", 64'(done_seen), 64'h0);
        m_hi = 0;
        m_lo = 0;
        run_op(3'd0, 32'hFFFF_FFFD, 32'h5, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
